// File: rtl/operand_fetch.sv
// Operand fetch: registered-read RF front end with busy-bit scoreboard and wb_q forwarding.
// Optional OPF_BYPASS_EN: same-cycle writeback bypass into S1 (saves one stall per RAW hit).
module operand_fetch #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic [AW-1:0]     in_rd,
    input  logic              in_wen,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [AW-1:0]     rf_rs1Adrs,
    output logic [AW-1:0]     rf_rs2Adrs,
    input  logic [XLEN-1:0]   rf_rs1Data,
    input  logic [XLEN-1:0]   rf_rs2Data,
    input  logic              wb_enable,
    input  logic [AW-1:0]     wb_rdAdrs,
    input  logic [XLEN-1:0]   wb_rdData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rs1Val,
    output logic [XLEN-1:0]   out_rs2Val,
    output logic [AW-1:0]     out_rd,
    output logic              out_wen,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              s1_valid;
    logic [AW-1:0]     s1_rs1, s1_rs2, s1_rd;
    logic              s1_wen;
    logic [CTRL_W-1:0] s1_ctrl;

    logic [NREG-1:0]   busy;
    logic              wbq_en;
    logic [AW-1:0]     wbq_rd;
    logic [XLEN-1:0]   wbq_data;

    logic              byp1, byp2;
    logic              rs1_rdy, rs2_rdy, waw_ok;
    logic              advance, s1_open;
    logic [XLEN-1:0]   rs1_val, rs2_val;

`ifdef OPF_BYPASS_EN
    assign byp1 = wb_enable && (wb_rdAdrs == s1_rs1);
    assign byp2 = wb_enable && (wb_rdAdrs == s1_rs2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    function automatic logic [XLEN-1:0] pick_val(
        input logic [AW-1:0]   rs,
        input logic            byp,
        input logic [XLEN-1:0] rf_data,
        input logic [XLEN-1:0] wb_data,
        input logic            q_en,
        input logic [AW-1:0]   q_rd,
        input logic [XLEN-1:0] q_data
    );
        // x0 storage is never reset, so its read data must not leak out
        if (rs == '0)
            pick_val = '0;
        else if (byp)
            pick_val = wb_data;
        else if (q_en && (q_rd == rs))
            pick_val = q_data;
        else
            pick_val = rf_data;
    endfunction

    assign rs1_rdy = (s1_rs1 == '0) || !busy[s1_rs1] || byp1;
    assign rs2_rdy = (s1_rs2 == '0) || !busy[s1_rs2] || byp2;
    assign waw_ok  = !(s1_wen && (s1_rd != '0)) || !busy[s1_rd];

    assign rs1_val = pick_val(s1_rs1, byp1, rf_rs1Data, wb_rdData, wbq_en, wbq_rd, wbq_data);
    assign rs2_val = pick_val(s1_rs2, byp2, rf_rs2Data, wb_rdData, wbq_en, wbq_rd, wbq_data);

    assign advance  = s1_valid && rs1_rdy && rs2_rdy && waw_ok
                      && (!out_valid || out_ready) && !flush;
    assign s1_open  = !s1_valid || advance;
    assign in_ready = !flush && s1_open;

    // A stalled S1 keeps re-reading its own sources so it sees fresh RF contents
    assign rf_rs1Adrs = s1_open ? in_rs1 : s1_rs1;
    assign rf_rs2Adrs = s1_open ? in_rs2 : s1_rs2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_rd    <= '0;
            s1_wen   <= 1'b0;
            s1_ctrl  <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_open) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_rs1  <= in_rs1;
                s1_rs2  <= in_rs2;
                s1_rd   <= in_rd;
                s1_wen  <= in_wen;
                s1_ctrl <= in_ctrl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_rs1Val <= '0;
            out_rs2Val <= '0;
            out_rd     <= '0;
            out_wen    <= 1'b0;
            out_ctrl   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid  <= 1'b1;
            out_rs1Val <= rs1_val;
            out_rs2Val <= rs2_val;
            out_rd     <= s1_rd;
            out_wen    <= s1_wen;
            out_ctrl   <= s1_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Set is applied after clear so a same-cycle set on the same index wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (wb_enable && (wb_rdAdrs != '0))
                busy[wb_rdAdrs] <= 1'b0;
            if (advance && s1_wen && (s1_rd != '0))
                busy[s1_rd] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbq_en   <= 1'b0;
            wbq_rd   <= '0;
            wbq_data <= '0;
        end else begin
            wbq_en   <= wb_enable;
            wbq_rd   <= wb_rdAdrs;
            wbq_data <= wb_rdData;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed hazard/flush/reset cases, then random traffic
// checked against an in-order architectural register model.
module tb_operand_fetch;
    localparam int NI = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic        in_wen = 1'b0;
    logic [15:0] in_ctrl = '0;
    logic [4:0]  rf_rs1Adrs, rf_rs2Adrs;
    logic [31:0] rf_rs1Data, rf_rs2Data;
    logic        wb_enable = 1'b0;
    logic [4:0]  wb_rdAdrs = '0;
    logic [31:0] wb_rdData = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_rs1Val, out_rs2Val;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [15:0] out_ctrl;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen), .in_ctrl(in_ctrl),
        .rf_rs1Adrs(rf_rs1Adrs), .rf_rs2Adrs(rf_rs2Adrs),
        .rf_rs1Data(rf_rs1Data), .rf_rs2Data(rf_rs2Data),
        .wb_enable(wb_enable), .wb_rdAdrs(wb_rdAdrs), .wb_rdData(wb_rdData),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1Val(out_rs1Val), .out_rs2Val(out_rs2Val),
        .out_rd(out_rd), .out_wen(out_wen), .out_ctrl(out_ctrl)
    );

    always #5 clk = ~clk;

    // Register file model: registered read, write visible only from the next read
    logic [31:0] mem [32];
    always @(posedge clk) begin
        rf_rs1Data <= mem[rf_rs1Adrs];
        rf_rs2Data <= mem[rf_rs2Adrs];
        if (wb_enable) mem[wb_rdAdrs] <= wb_rdData;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wen, input logic [15:0] ctrl);
        in_valid = 1'b1;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wen = wen; in_ctrl = ctrl;
    endtask

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
        wb_enable = 1'b1; wb_rdAdrs = rd; wb_rdData = d;
        tick();
        wb_enable = 1'b0;
    endtask

    logic [85:0] exp_q [$];
    logic [31:0] wbv_q [$];
    logic [4:0]  prd [$];
    logic [31:0] pdat [$];
    int          pdue [$];
    logic [31:0] shadow [32];
    logic [15:0] exp_ctrl [3];
    logic [85:0] got, e;
    logic [86:0] snap;
    logic        hold_pend;
    logic [31:0] v1, v2, wv;
    int          k, issued;

    initial begin
        exp_ctrl = '{16'h0040, 16'h0041, 16'h0042};
        // reset state
        repeat (2) tick();
        chk("rst_out", {out_valid, out_rs1Val, out_rs2Val, out_rd, out_wen, out_ctrl}, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 32; i++)
            wb_write(5'(i), (i == 3) ? 32'h1234 : (i == 0) ? 32'hBAD0_0BAD : (32'hA000_0000 | 32'(i)));
        tick();

        // basic latency, x0 reads as zero
        issue(5'd3, 5'd0, 5'd0, 1'b0, 16'h0001);
        #1 chk("t1_in_ready", in_ready, 1'b1);
        tick(); in_valid = 1'b0;
        chk("t1_not_yet", out_valid, 1'b0);
        tick();
        chk("t1_out", {out_valid, out_rs1Val, out_rs2Val, out_ctrl}, {1'b1, 32'h1234, 32'h0, 16'h0001});
        repeat (2) tick();

        // RAW on x5
        issue(5'd0, 5'd0, 5'd5, 1'b1, 16'h0021);
        tick();
        issue(5'd5, 5'd0, 5'd0, 1'b0, 16'h0022);
        tick(); in_valid = 1'b0;
        chk("t2_a_out", {out_valid, out_rd, out_ctrl}, {1'b1, 5'd5, 16'h0021});
        tick(); chk("t2_b_stall0", out_valid, 1'b0);
        tick(); chk("t2_b_stall1", out_valid, 1'b0);
        wb_write(5'd5, 32'hDEAD);
`ifdef OPF_BYPASS_EN
        chk("t2_b_out", {out_valid, out_rs1Val, out_ctrl}, {1'b1, 32'hDEAD, 16'h0022});
        tick();
`else
        chk("t2_b_wait", out_valid, 1'b0);
        tick();
        chk("t2_b_out", {out_valid, out_rs1Val, out_ctrl}, {1'b1, 32'hDEAD, 16'h0022});
`endif
        repeat (2) tick();

        // writeback on the same edge as the accept must come from wb_q
        issue(5'd0, 5'd7, 5'd0, 1'b0, 16'h0030);
        wb_enable = 1'b1; wb_rdAdrs = 5'd7; wb_rdData = 32'hBEEF;
        tick(); in_valid = 1'b0; wb_enable = 1'b0;
        tick();
        chk("t3_out", {out_valid, out_rs2Val, out_ctrl}, {1'b1, 32'hBEEF, 16'h0030});
        repeat (2) tick();

        // backpressure: stable outputs, order kept
        out_ready = 1'b0;
        issue(5'd3, 5'd0, 5'd0, 1'b0, 16'h0040);
        tick();
        issue(5'd3, 5'd0, 5'd0, 1'b0, 16'h0041);
        tick();
        issue(5'd3, 5'd0, 5'd0, 1'b0, 16'h0042);
        #1 chk("t4_in_ready_low", in_ready, 1'b0);
        tick();
        chk("t4_hold0", {out_valid, out_rs1Val, out_ctrl}, {1'b1, 32'h1234, 16'h0040});
        tick();
        chk("t4_hold1", {out_valid, out_rs1Val, out_ctrl}, {1'b1, 32'h1234, 16'h0040});
        out_ready = 1'b1;
        #1 chk("t4_in_ready_back", in_ready, 1'b1);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                if (k < 3) chk("t4_order", out_ctrl, exp_ctrl[k]);
                k++;
            end
            tick();
            in_valid = 1'b0;
        end
        chk("t4_count", k, 3);

        // WAW on x9, then a reader that must wait for the second writer
        issue(5'd0, 5'd0, 5'd9, 1'b1, 16'h0050);
        tick();
        issue(5'd0, 5'd0, 5'd9, 1'b1, 16'h0051);
        tick(); in_valid = 1'b0;
        chk("t5_a_out", {out_valid, out_ctrl}, {1'b1, 16'h0050});
        tick(); chk("t5_c_stall0", out_valid, 1'b0);
        tick(); chk("t5_c_stall1", out_valid, 1'b0);
        wb_write(5'd9, 32'h0900);
        chk("t5_c_stall2", out_valid, 1'b0);
        tick();
        chk("t5_c_out", {out_valid, out_rd, out_wen, out_ctrl}, {1'b1, 5'd9, 1'b1, 16'h0051});
        issue(5'd9, 5'd0, 5'd0, 1'b0, 16'h0052);
        tick(); in_valid = 1'b0;
        chk("t5_d_stall0", out_valid, 1'b0);
        tick(); chk("t5_d_stall1", out_valid, 1'b0);
        tick(); chk("t5_d_stall2", out_valid, 1'b0);
        wb_write(5'd9, 32'h0099);
        for (int i = 0; i < 6; i++) begin
            if (out_valid) break;
            tick();
        end
        chk("t5_d_out", {out_valid, out_rs1Val, out_ctrl}, {1'b1, 32'h0099, 16'h0052});
        repeat (2) tick();

        // flush with both stages full and x4 busy
        out_ready = 1'b0;
        issue(5'd0, 5'd0, 5'd4, 1'b1, 16'h0060);
        tick();
        issue(5'd0, 5'd0, 5'd0, 1'b0, 16'h0061);
        tick();
        issue(5'd0, 5'd0, 5'd0, 1'b0, 16'h0062);
        flush = 1'b1;
        #1 chk("t6_in_ready_flush", in_ready, 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("t6_flushed", out_valid, 1'b0);
        tick();
        chk("t6_dropped", out_valid, 1'b0);
        issue(5'd4, 5'd0, 5'd0, 1'b0, 16'h0063);
        tick(); in_valid = 1'b0;
        tick();
        chk("t6_busy_clear", {out_valid, out_rs1Val, out_ctrl}, {1'b1, 32'hA000_0004, 16'h0063});
        repeat (2) tick();

        // async reset in the middle of a stall
        out_ready = 1'b0;
        issue(5'd3, 5'd0, 5'd6, 1'b1, 16'h0070);
        tick();
        issue(5'd6, 5'd0, 5'd0, 1'b0, 16'h0071);
        tick(); in_valid = 1'b0;
        tick();
        chk("t7_pre", {out_valid, out_rs1Val, out_ctrl}, {1'b1, 32'h1234, 16'h0070});
        #2 rst_n = 1'b0;
        #1 chk("t7_async", {out_valid, out_rs1Val, out_rs2Val, out_rd, out_wen, out_ctrl}, '0);
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        chk("t7_after", out_valid, 1'b0);
        tick();

        // random traffic against the architectural model
        for (int i = 0; i < 32; i++) shadow[i] = mem[i];
        shadow[0] = '0;
        issued = 0;
        hold_pend = 1'b0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            if (issued == NI && exp_q.size() == 0 && prd.size() == 0) break;
            got = {out_rs1Val, out_rs2Val, out_rd, out_wen, out_ctrl};
            if (hold_pend) chk("hold", {out_valid, got}, snap);
            hold_pend = 1'b0;
            wb_enable = 1'b0;
            wb_rdAdrs = 5'($urandom);
            wb_rdData = $urandom;
            for (int i = 0; i < prd.size(); i++) begin
                if (pdue[i] <= cyc) begin
                    wb_enable = 1'b1; wb_rdAdrs = prd[i]; wb_rdData = pdat[i];
                    prd.delete(i); pdat.delete(i); pdue.delete(i);
                    break;
                end
            end
            in_valid = (issued < NI) && ($urandom_range(0, 9) < 7);
            in_rs1 = 5'($urandom_range(0, 7));
            in_rs2 = 5'($urandom_range(0, 7));
            in_rd  = 5'($urandom_range(0, 7));
            in_wen = ($urandom_range(0, 9) < 7);
            in_ctrl = 16'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    wv = wbv_q.pop_front();
                    chk("out", got, e);
                    if (e[16] && e[21:17] != 5'd0) begin
                        prd.push_back(e[21:17]);
                        pdat.push_back(wv);
                        pdue.push_back(cyc + 1 + int'($urandom_range(0, 4)));
                    end
                end
            end
            if (out_valid && !out_ready) begin
                snap = {1'b1, got};
                hold_pend = 1'b1;
            end
            if (in_valid && in_ready) begin
                v1 = (in_rs1 == 5'd0) ? 32'h0 : shadow[in_rs1];
                v2 = (in_rs2 == 5'd0) ? 32'h0 : shadow[in_rs2];
                wv = $urandom;
                exp_q.push_back({v1, v2, in_rd, in_wen, in_ctrl});
                wbv_q.push_back(wv);
                if (in_wen && in_rd != 5'd0) shadow[in_rd] = wv;
                issued++;
            end
            tick();
        end
        in_valid = 1'b0;
        wb_enable = 1'b0;
        chk("drain", {issued == NI, exp_q.size() == 0, prd.size() == 0}, 3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-to-execute stage that sits directly in front of the register file and consumes its registered read data.
- Accepts decoded instructions and drives the register file read addresses, one cycle before it needs the data.
- Resolves RAW/WAW hazards with a busy-bit scoreboard and forwards writeback data the register file cannot yet return.
- Delivers the resolved operands to execute over a valid/ready handshake.

Parameters:
XLEN, 32, data width; must match register file data width
NREG, 32, architectural register count
AW, 5, register address width (log2 NREG)
CTRL_W, 16, width of opaque control word passed through to execute

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous pipeline flush
in_valid  in  1  decoded instruction valid
in_ready  out  1  stage can accept
in_rs1  in  AW  source 1 index
in_rs2  in  AW  source 2 index
in_rd  in  AW  destination index
in_wen  in  1  instruction writes in_rd
in_ctrl  in  CTRL_W  pass-through control
rf_rs1Adrs  out  AW  register file read address 1
rf_rs2Adrs  out  AW  register file read address 2
rf_rs1Data  in  XLEN  register file read data 1; registered, 1-cycle latency
rf_rs2Data  in  XLEN  register file read data 2
wb_enable  in  1  writeback strobe; the same bus that drives the register file write port
wb_rdAdrs  in  AW  writeback index
wb_rdData  in  XLEN  writeback data
out_valid  out  1  operands valid to execute
out_ready  in  1  execute accepts
out_rs1Val  out  XLEN  resolved operand 1
out_rs2Val  out  XLEN  resolved operand 2
out_rd  out  AW  destination index
out_wen  out  1  destination write flag
out_ctrl  out  CTRL_W  control pass-through

Behaviour:
- Clock and reset: single clock `clk`; `rst_n` asynchronous, active-low.
- Reset values: S1 valid = 0, out_valid = 0, all busy bits = 0, wb_q = 0, all out_* data = 0.
- Pipeline: two stages.
  - S1: instruction registered while its register file read is in flight.
  - S2: the output register.
- Read addressing:
  - rf_rs*Adrs = in_rs* when S1 is empty or advancing, else the S1-held rs*.
  - A stalled S1 therefore re-reads every cycle and sees fresh register file contents.
- wb_q: the writeback bus registered every cycle. It covers writes that landed on the same edge as the read, which the register file returns as old data.
- Source ready (per source, in S1): rs == 0, or busy[rs] == 0.
- WAW: S1 with wen && rd != 0 additionally needs busy[rd] == 0.
- Operand value priority:
  - rs == 0 -> 0; never use register file data for x0, since x0 is unreset storage.
  - else wb_q match (wb_q.en && wb_q.rd == rs) -> wb_q.data.
  - else rf_rs*Data.
- S1 advances to S2 when all sources are ready and (!out_valid || out_ready).
- in_ready = !S1.valid || S1 advances. This is combinational; no bubble on back-to-back issue.
- Latency: accept at edge E, out_valid at edge E+1 with no hazard. Throughput 1/cycle.
- Scoreboard:
  - Advance with wen && rd != 0 sets busy[rd].
  - wb_enable && wb_rdAdrs != 0 clears busy[wb_rdAdrs].
  - Set and clear of the same index in the same cycle: set wins.
  - busy[0] is never set.
- S2 outputs hold stable while out_valid && !out_ready.
- flush:
  - Next edge: S1 valid = 0, out_valid = 0, all busy = 0.
  - in_ready = 0 during the flush cycle; in_valid is ignored in that cycle.
  - Asserted only once no older writer is still pending.
- Async reset mid-operation: everything returns to reset values immediately; in-flight instructions are discarded.

Optional Feature:
- Macro: OPF_BYPASS_EN.
- Defined: a source is also ready when wb_enable && wb_rdAdrs == rs in the current cycle. Its value is wb_rdData, ahead of wb_q in priority. This saves one stall cycle per RAW hit.
- Undefined: no combinational wb path. The consumer waits for busy to clear and takes the value from wb_q. Adds 1 cycle per RAW hazard; timing path shortens.

Test Plan:
- Reset, issue rs1=3, rs2=0 with reg3=0x1234 -> out_valid 1 cycle after accept; out_rs1Val=0x1234, out_rs2Val=0.
- Issue A: rd=5, wen. Next cycle issue B: rs1=5. Writeback x5=0xDEAD three cycles later -> B held until then; with OPF_BYPASS_EN B advances in the wb cycle, without it one cycle later. out_rs1Val=0xDEAD both ways.
- wb x7=0xBEEF on the same edge B (rs2=7, x7 not busy) is accepted -> out_rs2Val=0xBEEF via wb_q, not stale register file data.
- out_ready=0 for 4 cycles with 3 instructions issued -> outputs stable, in_ready drops after S1 fills, no loss or duplication, order preserved.
- A rd=9 in flight, then C wen rd=9 -> C stalls until A's writeback; busy[9] stays set for C.
- flush with S1/S2 full and busy[4] set -> next cycle out_valid=0, busy all 0; rst_n pulse mid-stall -> all outputs 0 asynchronously.
